image_ram_writer: RTL

- Loads a sprite/background image into a single-port block RAM from a pixel stream (valid/ready, raster order, end-of-frame marker).
- Write-side counterpart of the per-pixel image ROM readers in the video pipeline.
- Generates raster addresses incrementally, registers the BRAM write port, and flags short and long frames.
- Sits between the image source (UART/debug loader) and the BRAM port A that the display readers share.

---
 rtl/img_pkg.sv | 18 +
 rtl/raster_addr_gen.sv | 48 ++++
 rtl/image_ram_writer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared types and default geometry for the image RAM loader and the display readers.
package img_pkg;

  localparam int DEF_IMG_WIDTH   = 400;
  localparam int DEF_IMG_HEIGHT  = 457;
  localparam int DEF_COLOR_WIDTH = 12;
  localparam int IMG_PIXELS      = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

  typedef logic [DEF_COLOR_WIDTH-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FLUSH,
    DONE
  } wr_state_t;

endpackage

// File: rtl/raster_addr_gen.sv
// Raster col/row/address counters; the address is a running count, so no multiply is needed.
module raster_addr_gen #(
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 457,
  parameter int ADDR_WIDTH = 18,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_eof
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0]         COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]         ROW_MAX = RW'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR0   = ADDR_WIDTH'(BASE_ADDR);

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_col_end;

  assign w_col_end = (r_col == COL_MAX);
  assign o_eof     = w_col_end && (r_row == ROW_MAX);
  assign o_addr    = r_addr;

  // Counters saturate on the last pixel so the address never leaves the image.
  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= ADDR0;
    end else if (i_advance && !o_eof) begin
      r_addr <= r_addr + 1'b1;
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_ram_writer.sv
// Streams one raster-order image frame into BRAM port A, flagging short and long source frames.
module image_ram_writer
  import img_pkg::*;
#(
  parameter int IMG_WIDTH   = 400,
  parameter int IMG_HEIGHT  = 457,
  parameter int COLOR_WIDTH = 12,
  parameter int ADDR_WIDTH  = 18,
  parameter int BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic [COLOR_WIDTH-1:0] i_s_data,
  input  logic                   i_s_last,
  output logic                   o_mem_we,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  output logic [COLOR_WIDTH-1:0] o_mem_din,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err_short,
  output logic                   o_err_long,
  output logic [ADDR_WIDTH-1:0]  o_pix_count
);

  localparam logic [ADDR_WIDTH-1:0] ADDR0 = ADDR_WIDTH'(BASE_ADDR);

  wr_state_t              r_state;
  logic                   r_s_ready;
  logic                   r_mem_we;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [COLOR_WIDTH-1:0] r_mem_din;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err_short;
  logic                   r_err_long;
  logic [ADDR_WIDTH-1:0]  r_pix_count;

  logic                   w_accept;
  logic                   w_clear;
  logic                   w_advance;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic                   w_eof;

  assign w_accept  = i_s_valid && r_s_ready;
  assign w_clear   = (r_state == IDLE) && i_start && !i_abort;
  assign w_advance = (r_state == WRITE) && w_accept;

  raster_addr_gen #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_advance(w_advance),
    .o_addr   (w_addr),
    .o_eof    (w_eof)
  );

  // Every output is registered; s_ready follows the next state, never s_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_s_ready   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= ADDR0;
      r_mem_din   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_pix_count <= '0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_clear) begin
            r_state     <= WRITE;
            r_busy      <= 1'b1;
            r_s_ready   <= 1'b1;
            r_pix_count <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
          end
        end
        WRITE: begin
          if (w_accept) begin
            r_mem_we    <= 1'b1;
            r_mem_din   <= i_s_data;
            r_mem_addr  <= w_addr;
            r_pix_count <= r_pix_count + 1'b1;
          end
          // Abort still lets the beat of this cycle land but leaves the flags alone.
          if (i_abort || (w_accept && (w_eof ? i_s_last : i_s_last))) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b0;
            if (!i_abort && !w_eof) r_err_short <= 1'b1;
          end else if (w_accept && w_eof) begin
            r_state    <= FLUSH;
            r_err_long <= 1'b1;
          end
        end
        FLUSH: begin
          if (i_abort || (w_accept && i_s_last)) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_s_ready   = r_s_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_din   = r_mem_din;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err_short = r_err_short;
  assign o_err_long  = r_err_long;
  assign o_pix_count = r_pix_count;

endmodule
